// File: rtl/mem_bist_pkg.sv
// mem_bist_pkg: shared constants for the memory BIST sequencer.
// Holds default widths, the FSM state encoding and the expected run length.
package mem_bist_pkg;

    localparam int ADDR_W_DEF  = 5;
    localparam int DATA_W_DEF  = 8;

    // Cycles spent with busy high: four 32-entry sweeps plus two drain cycles.
    localparam int BUSY_CYCLES = 130;

    localparam int STATE_W = 3;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CLR_WR   = 3'd1;
    localparam logic [2:0] ST_CLR_RD   = 3'd2;
    localparam logic [2:0] ST_CLR_DRAIN = 3'd3;
    localparam logic [2:0] ST_DA_WR    = 3'd4;
    localparam logic [2:0] ST_DA_RD    = 3'd5;
    localparam logic [2:0] ST_DA_DRAIN = 3'd6;
    localparam logic [2:0] ST_FIN      = 3'd7;

    // A run is in progress in every state except IDLE and FIN.
    function automatic logic is_busy_state(input logic [2:0] s);
        return (s != ST_IDLE) && (s != ST_FIN);
    endfunction

endpackage

// File: rtl/mem_bist_checker.sv
// mem_bist_checker: read-compare pipeline and mismatch accumulator.
// Each read strobe registers the expected value; the compare happens the
// following cycle when the memory presents its data.
// Optional first-failure log is built when MEM_BIST_FAIL_LOG_EN is defined.
module mem_bist_checker
    import mem_bist_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              rd_i,
    input  logic [DATA_W-1:0] exp_i,
    input  logic [DATA_W-1:0] mem_data_out_i,
`ifdef MEM_BIST_FAIL_LOG_EN
    input  logic [ADDR_W-1:0] addr_i,
    output logic              fail_valid_o,
    output logic [ADDR_W-1:0] fail_addr_o,
    output logic [DATA_W-1:0] fail_exp_o,
    output logic [DATA_W-1:0] fail_act_o,
`endif
    output logic [ADDR_W+1:0] err_count_o,
    output logic [ADDR_W+1:0] err_next_o
);

    logic              chk_valid_q;
    logic [DATA_W-1:0] chk_exp_q;
    logic [ADDR_W+1:0] err_q;
    logic              mismatch;

    // Four-state compare so that X/Z read data is treated as a failure.
    always_comb begin
        mismatch   = chk_valid_q && (mem_data_out_i !== chk_exp_q);
        err_next_o = err_q + {{(ADDR_W+1){1'b0}}, mismatch};
    end

    assign err_count_o = err_q;

    // Compare pipeline stage: remember that a read was issued and what it should return.
    always_ff @(posedge clk) begin
        if (reset) begin
            chk_valid_q <= 1'b0;
            chk_exp_q   <= '0;
        end else begin
            chk_valid_q <= rd_i;
            chk_exp_q   <= exp_i;
        end
    end

    // Mismatch accumulator, cleared at reset and when a new run is accepted.
    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            err_q <= '0;
        end else begin
            err_q <= err_next_o;
        end
    end

`ifdef MEM_BIST_FAIL_LOG_EN
    logic [ADDR_W-1:0] chk_addr_q;
    logic              fail_valid_q;
    logic [ADDR_W-1:0] fail_addr_q;
    logic [DATA_W-1:0] fail_exp_q;
    logic [DATA_W-1:0] fail_act_q;

    // Address that goes with the pending compare.
    always_ff @(posedge clk) begin
        if (reset) begin
            chk_addr_q <= '0;
        end else begin
            chk_addr_q <= addr_i;
        end
    end

    // Capture only the first mismatch of a run; held until next start or reset.
    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            fail_valid_q <= 1'b0;
            fail_addr_q  <= '0;
            fail_exp_q   <= '0;
            fail_act_q   <= '0;
        end else if (mismatch && !fail_valid_q) begin
            fail_valid_q <= 1'b1;
            fail_addr_q  <= chk_addr_q;
            fail_exp_q   <= chk_exp_q;
            fail_act_q   <= mem_data_out_i;
        end
    end

    assign fail_valid_o = fail_valid_q;
    assign fail_addr_o  = fail_addr_q;
    assign fail_exp_o   = fail_exp_q;
    assign fail_act_o   = fail_act_q;
`endif

endmodule

// File: rtl/mem_bist_ctrl.sv
// mem_bist_ctrl: two-phase memory BIST sequencer (clear test, then
// data=address test) driving a synchronous single-port memory.
// Optional feature macro: MEM_BIST_FAIL_LOG_EN adds the first-failure log ports.
// Handshake: start is a level sampled only in IDLE; done is a one-cycle pulse
// in FIN, and pass/err_count are valid from done until the next accepted start.
module mem_bist_ctrl
    import mem_bist_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ADDR_W+1:0]  err_count,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_data_in,
    output logic               mem_write,
    output logic               mem_read,
    input  logic [DATA_W-1:0]  mem_data_out,
`ifdef MEM_BIST_FAIL_LOG_EN
    output logic               fail_valid,
    output logic [ADDR_W-1:0]  fail_addr,
    output logic [DATA_W-1:0]  fail_exp,
    output logic [DATA_W-1:0]  fail_act,
`endif
    output logic [STATE_W-1:0] dbg_state_o
);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pass_q, pass_d;
    logic              addr_last;
    logic              start_acc;
    logic [DATA_W-1:0] addr_ext;
    logic [DATA_W-1:0] exp_data;
    logic [ADDR_W+1:0] err_next;

    // Terminal count on the address counter marks the end of each sweep.
    always_comb begin
        addr_last = (addr_q == {ADDR_W{1'b1}});
        start_acc = (state_q == ST_IDLE) && start;
        addr_ext  = DATA_W'(addr_q);
    end

    // Next-state, address counter and pass flag.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pass_d  = pass_q;
        case (state_q)
            ST_IDLE: begin
                addr_d = '0;
                if (start) begin
                    state_d = ST_CLR_WR;
                    pass_d  = 1'b0;
                end
            end
            ST_CLR_WR, ST_CLR_RD, ST_DA_WR, ST_DA_RD: begin
                if (addr_last) begin
                    addr_d = '0;
                    case (state_q)
                        ST_CLR_WR: state_d = ST_CLR_RD;
                        ST_CLR_RD: state_d = ST_CLR_DRAIN;
                        ST_DA_WR:  state_d = ST_DA_RD;
                        default:   state_d = ST_DA_DRAIN;
                    endcase
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            ST_CLR_DRAIN: state_d = ST_DA_WR;
            ST_DA_DRAIN: begin
                // The last compare resolves this cycle, so err_next is the final count.
                state_d = ST_FIN;
                pass_d  = (err_next == '0);
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pass_q  <= pass_d;
        end
    end

    // Memory strobes and status decoded from the registered state.
    always_comb begin
        mem_write   = (state_q == ST_CLR_WR) || (state_q == ST_DA_WR);
        mem_read    = (state_q == ST_CLR_RD) || (state_q == ST_DA_RD);
        mem_addr    = addr_q;
        mem_data_in = (state_q == ST_DA_WR) ? addr_ext : '0;
        exp_data    = (state_q == ST_DA_RD) ? addr_ext : '0;
        busy        = is_busy_state(state_q);
        done        = (state_q == ST_FIN);
        pass        = pass_q;
        dbg_state_o = state_q;
    end

    mem_bist_checker #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_checker (
        .clk            (clk),
        .reset          (reset),
        .clr_i          (start_acc),
        .rd_i           (mem_read),
        .exp_i          (exp_data),
        .mem_data_out_i (mem_data_out),
`ifdef MEM_BIST_FAIL_LOG_EN
        .addr_i         (addr_q),
        .fail_valid_o   (fail_valid),
        .fail_addr_o    (fail_addr),
        .fail_exp_o     (fail_exp),
        .fail_act_o     (fail_act),
`endif
        .err_count_o    (err_count),
        .err_next_o     (err_next)
    );

endmodule

// File: doc/mem_bist_ctrl.md
Name: mem_bist_ctrl

Overview:
Hardware built-in self-test sequencer that sits directly upstream of the 32x8 synchronous memory and drives its addr/data_in/read/write pins. It consumes the memory's data_out. It runs the two-phase test in hardware: a clear test, which writes 0 everywhere and checks, followed by a data=address test. It then reports pass/fail and an error count. It replaces the bench-driven stimulus when the memory is embedded in a larger design.

Parameters:
ADDR_W, 5, memory address width; depth = 2**ADDR_W (32)
DATA_W, 8, memory data width

Ports:
clk  input  1  single clock; all logic on posedge
reset  input  1  synchronous, active-high reset
start  input  1  request a test run; sampled only in IDLE
busy  output  1  high while a test is in progress
done  output  1  one-cycle pulse when the test completes
pass  output  1  1 = last run had zero errors; valid from done until next start
err_count  output  ADDR_W+2  total mismatches in last run (max 2*depth = 64)
mem_addr  output  ADDR_W  address to memory
mem_data_in  output  DATA_W  write data to memory
mem_write  output  1  memory write strobe
mem_read  output  1  memory read strobe
mem_data_out  input  DATA_W  memory read data, valid the cycle after mem_read

Behaviour:
- Memory contract: write occurs on the posedge where mem_write=1. With mem_read=1 at edge N, mem_data_out is valid during cycle N+1. mem_read and mem_write are never both high.
- Reset: state=IDLE; busy, done, mem_write, mem_read, mem_addr, mem_data_in = 0; pass=0; err_count=0.
- FSM states, in sequence:
  - IDLE: start=1 -> CLR_WR; clear err_count and pass; busy=1 from the next cycle.
  - CLR_WR: mem_write=1, mem_data_in=0, addr 0..31, one per cycle; after addr 31 -> CLR_RD.
  - CLR_RD: mem_read=1, addr 0..31, one per cycle; expected value 0; after addr 31 -> CLR_DRAIN.
  - CLR_DRAIN: 1 cycle, strobes low; last compare completes -> DA_WR.
  - DA_WR: mem_data_in = addr, zero-extended or truncated to DATA_W.
  - DA_RD: expected value = addr, same width rule.
  - DA_DRAIN -> FIN.
  - FIN: done=1 for 1 cycle, busy=0, pass=(err_count==0) -> IDLE.
- Busy duration: 130 cycles (4x32 + 2 drains). done is asserted on cycle 131 after start is sampled.
- Compare pipeline: each read registers {chk_valid, exp_data}. In the following cycle, if chk_valid and mem_data_out !== exp_data, err_count increments by 1. X or Z on mem_data_out counts as a mismatch (4-state compare in simulation).
- Address counter: ADDR_W bits. The wrap from 31 to 0 is the phase-transition event, detected on terminal count and not on overflow.
- start while busy: ignored. start held high in FIN: not accepted until IDLE.
- Reset mid-run: returns to IDLE on the next edge with all strobes low. Any in-flight compare is discarded; err_count=0.
- start and reset in the same cycle: reset wins.
- err_count is live during the run; pass is updated only in FIN.

Optional Feature:
MEM_BIST_FAIL_LOG_EN:
- Defined: adds outputs fail_valid (1), fail_addr (ADDR_W), fail_exp (DATA_W), fail_act (DATA_W). These capture the first mismatch of the run and hold it until the next start or reset. fail_valid=0 otherwise.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package mem_bist_pkg: state enum (IDLE, CLR_WR, CLR_RD, CLR_DRAIN, DA_WR, DA_RD, DA_DRAIN, FIN), default width constants, and BUSY_CYCLES=130.
- Sub-module mem_bist_checker: compare pipeline register, err_count accumulator, and the optional fail log.
- The FSM and address counter stay in the top module.

Test Plan:
- Healthy memory model, start pulse at cycle 10 -> busy for 130 cycles; done pulses once; pass=1; err_count=0. Memory contents at end: mem[i]=i.
- Model with bit 3 of addr 5 stuck at 1 -> clear phase 1 error, data=address phase passes (5 already has bit 3=0? no: 5=0b101, bit3 forced to 1 -> error). Required: err_count=2, pass=0. With MEM_BIST_FAIL_LOG_EN: fail_addr=5, fail_exp=0, fail_act=8'h08.
- Model with a stuck read-data output of 8'hFF -> err_count=64, pass=0; no counter overflow.
- reset asserted at cycle 50 of a run -> next edge: busy=0, mem_write=mem_read=0, err_count=0. A new start then gives a clean 130-cycle run with pass=1.
- start re-pulsed during DA_WR, and held high through FIN -> the run is not restarted; exactly one done. The next run begins only after IDLE is observed.
- Protocol assertions throughout all tests: never mem_read&&mem_write; mem_addr increments by 1 per active cycle; done is always 1 cycle wide.
